// File: rtl/sobel_grad_gen_if.sv
// Pixel-in / gradient-out stream bundle for sobel_grad_gen.
// Both directions use the valid/ready handshake of the image path.
interface sobel_grad_gen_if;
  logic [23:0] input_data;
  logic        input_valid;
  logic        input_ready;
  logic        output_ready;
  logic        output_valid;
  logic [23:0] output_data;

  modport master (
    output input_data,
    output input_valid,
    input  input_ready,
    output output_ready,
    input  output_valid,
    input  output_data
  );

  modport slave (
    input  input_data,
    input  input_valid,
    output input_ready,
    input  output_ready,
    output output_valid,
    output output_data
  );
endinterface

// File: rtl/sobel_grad_gen.sv
// RGB raster stream -> luminance -> 3x3 Sobel window -> scaled gx/gy.
// Output word is {6'b0, gx[8:0], gy[8:0]}, one per interior pixel.
module sobel_grad_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic             clk,
  input logic             rstn,
  sobel_grad_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    wa [3];
  logic [7:0]    wb [3];
  logic          accept;
  logic          win_ok;
  logic [15:0]   lum;
  logic [7:0]    gray;
  logic [7:0]    top;
  logic [7:0]    mid;
  logic [9:0]    sx_l;
  logic [9:0]    sx_r;
  logic [9:0]    sy_t;
  logic [9:0]    sy_b;
  logic signed [10:0] gx_f;
  logic signed [10:0] gy_f;
  logic [23:0]   out_q;
  logic          vld_q;

  assign bus.input_ready  = !vld_q || bus.output_ready;
  assign bus.output_valid = vld_q;
  assign bus.output_data  = out_q;
  assign accept = bus.input_valid && bus.input_ready;

  assign lum = 16'd77  * {8'd0, bus.input_data[23:16]}
             + 16'd150 * {8'd0, bus.input_data[15:8]}
             + 16'd29  * {8'd0, bus.input_data[7:0]};
  assign gray = 8'(lum >> 8);

  assign top = lb1[col];
  assign mid = lb0[col];

  // wa/wb are the two older window columns; the incoming column
  // (top, mid, gray) completes the post-shift 3x3 window.
  assign sx_l = {2'd0, wa[0]} + {1'd0, wa[1], 1'd0} + {2'd0, wa[2]};
  assign sx_r = {2'd0, top} + {1'd0, mid, 1'd0} + {2'd0, gray};
  assign sy_t = {2'd0, wa[0]} + {1'd0, wb[0], 1'd0} + {2'd0, top};
  assign sy_b = {2'd0, wa[2]} + {1'd0, wb[2], 1'd0} + {2'd0, gray};

  assign gx_f = $signed({1'b0, sx_r}) - $signed({1'b0, sx_l});
  assign gy_f = $signed({1'b0, sy_b}) - $signed({1'b0, sy_t});

  assign win_ok = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= gray;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
      for (int i = 0; i < 3; i++) begin
        wa[i] <= '0;
        wb[i] <= '0;
      end
    end else if (accept) begin
      wa[0] <= wb[0];
      wa[1] <= wb[1];
      wa[2] <= wb[2];
      wb[0] <= top;
      wb[1] <= mid;
      wb[2] <= gray;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (accept && win_ok) begin
      out_q <= {6'd0, gx_f[10:2], gy_f[10:2]};
      vld_q <= 1'b1;
    end else if (bus.output_ready) begin
      vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sobel_grad_gen.sv
// Bench for sobel_grad_gen: pattern table, random stream vs
// frame-array reference, back-to-back frames and async reset.
module tb_sobel_grad_gen;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    string       name;
    logic [23:0] pa;
    logic [23:0] pb;
    int          mode;
    logic [23:0] edge_w;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sobel_grad_gen_if bus();

  sobel_grad_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int img [H][W];
  int mr = 0;
  int mc = 0;
  logic [23:0] exp_q [$];
  logic [23:0] got [$];
  int acc_cnt = 0;
  int first_out_acc = -1;
  logic last_acc = 1'b0;
  logic hold_pending = 1'b0;
  logic [23:0] hold_word = '0;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input logic [23:0] d);
    int k [3];
    int gx;
    int gy;
    logic [8:0] x9;
    logic [8:0] y9;
    k = '{1, 2, 1};
    img[mr][mc] = (77 * int'(d[23:16]) + 150 * int'(d[15:8])
                 + 29 * int'(d[7:0])) / 256;
    if (mr >= 2 && mc >= 2) begin
      gx = 0;
      gy = 0;
      for (int i = 0; i < 3; i++) begin
        gx += k[i] * (img[mr-2+i][mc] - img[mr-2+i][mc-2]);
        gy += k[i] * (img[mr][mc-2+i] - img[mr-2][mc-2+i]);
      end
      x9 = 9'(gx >>> 2);
      y9 = 9'(gy >>> 2);
      exp_q.push_back({6'd0, x9, y9});
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Called at a negedge; drives, checks, returns at next negedge.
  task automatic cycle(input logic v, input logic [23:0] d,
                       input logic ordy);
    logic [23:0] e;
    bus.input_valid = v;
    bus.input_data = d;
    bus.output_ready = ordy;
    #1;
    if (hold_pending)
      chk("stall_hold", bus.output_data, hold_word);
    if (bus.output_valid && !bus.output_ready)
      chk("stall_rdy", bus.input_ready, 0);
    if (bus.output_valid && first_out_acc < 0)
      first_out_acc = acc_cnt;
    if (bus.output_valid && bus.output_ready) begin
      got.push_back(bus.output_data);
      if (exp_q.size() == 0) begin
        chk("sb_extra", bus.output_data, 24'hxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", bus.output_data, e);
      end
    end
    last_acc = v && bus.input_ready;
    if (last_acc) begin
      model_accept(d);
      acc_cnt++;
    end
    hold_pending = bus.output_valid && !bus.output_ready;
    hold_word = bus.output_data;
    @(negedge clk);
  endtask

  function automatic logic [23:0] pix(input int mode,
      input logic [23:0] pa, input logic [23:0] pb,
      input int r, input int c);
    case (mode)
      1: return (c < 4) ? pa : pb;
      2: return (r < 3) ? pa : pb;
      3: return 24'($urandom);
      default: return pa;
    endcase
  endfunction

  function automatic logic [23:0] exp_at(input int mode,
      input logic [23:0] ew, input int k);
    int r;
    int c;
    r = 2 + k / (W - 2);
    c = 2 + k % (W - 2);
    if (mode == 1) return (c == 4 || c == 5) ? ew : 24'h0;
    if (mode == 2) return (r == 3 || r == 4) ? ew : 24'h0;
    return 24'h0;
  endfunction

  task automatic run_pixels(input int mode, input logic [23:0] pa,
      input logic [23:0] pb, input int n, input bit rnd);
    logic [23:0] px;
    int tries;
    for (int i = 0; i < n; i++) begin
      px = pix(mode, pa, pb, i / W, i % W);
      tries = 0;
      last_acc = 1'b0;
      while (!last_acc && tries < 200) begin
        cycle(rnd ? ($urandom_range(3) != 0) : 1'b1, px,
              rnd ? 1'($urandom_range(1)) : 1'b1);
        tries++;
      end
      if (!last_acc) chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (!bus.output_valid) break;
      cycle(1'b0, 24'h0, 1'b1);
    end
    chk("drain_valid", bus.output_valid, 0);
    chk("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"flat_gray",  24'h808080, 24'h808080, 0, 24'h000000};
    tbl[1] = '{"flat_white", 24'hFFFFFF, 24'hFFFFFF, 0, 24'h000000};
    tbl[2] = '{"vert_bw",    24'h000000, 24'hFFFFFF, 1, 24'h01FE00};
    tbl[3] = '{"vert_wb",    24'hFFFFFF, 24'h000000, 1, 24'h020200};
    tbl[4] = '{"horz_bw",    24'h000000, 24'hFFFFFF, 2, 24'h0000FF};
    tbl[5] = '{"horz_wb",    24'hFFFFFF, 24'h000000, 2, 24'h000101};

    rstn = 1'b0;
    bus.input_valid = 1'b0;
    bus.input_data = '0;
    bus.output_ready = 1'b0;
    #1;
    chk("rst_valid", bus.output_valid, 0);
    chk("rst_data", bus.output_data, 0);
    chk("rst_ready", bus.input_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[t]) begin
      got.delete();
      acc_cnt = 0;
      first_out_acc = -1;
      run_pixels(tbl[t].mode, tbl[t].pa, tbl[t].pb, W * H, 1'b0);
      drain();
      chk({tbl[t].name, "_cnt"}, got.size(), 24);
      chk({tbl[t].name, "_lat"}, first_out_acc, 19);
      for (int k = 0; k < got.size() && k < 24; k++)
        chk({tbl[t].name, "_word"}, got[k],
            exp_at(tbl[t].mode, tbl[t].edge_w, k));
    end

    got.delete();
    run_pixels(3, 24'h0, 24'h0, 2 * W * H, 1'b1);
    drain();
    chk("rand_cnt", got.size(), 48);

    got.delete();
    run_pixels(3, 24'h0, 24'h0, W * H, 1'b0);
    run_pixels(1, 24'h000000, 24'hFFFFFF, W * H, 1'b0);
    drain();
    chk("b2b_cnt", got.size(), 48);
    for (int k = 0; k < got.size() - 24 && k < 24; k++)
      chk("b2b_word", got[24 + k], exp_at(1, 24'h01FE00, k));

    got.delete();
    run_pixels(1, 24'h000000, 24'hFFFFFF, 3 * W + 4, 1'b0);
    chk("pre_rst_valid", bus.output_valid, 1);
    bus.input_valid = 1'b0;
    bus.output_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", bus.output_valid, 0);
    chk("arst_data", bus.output_data, 0);
    chk("arst_ready", bus.input_ready, 1);
    exp_q.delete();
    mr = 0;
    mc = 0;
    hold_pending = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    got.delete();
    acc_cnt = 0;
    first_out_acc = -1;
    run_pixels(1, 24'h000000, 24'hFFFFFF, W * H, 1'b0);
    drain();
    chk("post_rst_cnt", got.size(), 24);
    chk("post_rst_lat", first_out_acc, 2 * W + 3);
    for (int k = 0; k < got.size() && k < 24; k++)
      chk("post_rst_word", got[k], exp_at(1, 24'h01FE00, k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
